// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - start/result handshake bundle for the sequential divider
//
// Purpose: groups the divide request (start, operands, mode bits) and the
// status/result signals (busy, done, exc, out) shared by microcode and div_seq.
//
// Signals:
//   start      microcode -> divider  begin a divide (sampled only when idle)
//   signed_op  microcode -> divider  1 = IDIV, 0 = DIV
//   word_op    microcode -> divider  1 = 32/16, 0 = 16/8
//   x[31:0]    microcode -> divider  dividend (byte mode uses x[15:0])
//   y[15:0]    microcode -> divider  divisor  (byte mode uses y[7:0])
//   busy       divider -> microcode  high whenever the divider is not idle
//   done       divider -> microcode  one-cycle completion pulse
//   exc        divider -> microcode  divide error, qualified by done
//   out[31:0]  divider -> microcode  {remainder, quotient}
//
// Modports: master = microcode side, slave = divider side.

interface div_seq_if;
  logic        start;
  logic        signed_op;
  logic        word_op;
  logic [31:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic        exc;
  logic [31:0] out;

  modport master (
    output start, signed_op, word_op, x, y,
    input  busy, done, exc, out
  );

  modport slave (
    input  start, signed_op, word_op, x, y,
    output busy, done, exc, out
  );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider for 8086 DIV/IDIV
//
// Purpose: one quotient bit per cycle shift-subtract divider with operand
// latching, sign pre/post-processing and divide-error detection.
// Sequence: IDLE -> PREP -> ITER (W cycles) -> FIX -> DONE, or
// IDLE -> PREP -> DONE on a zero divisor / quotient overflow.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    div_seq_if.slave (start, signed_op, word_op, x, y in;
//          busy, done, exc, out out)
//
// Build option: define DIV_NEG_MAX_EN to accept a quotient of exactly
// -2^(W-1) (80186 behaviour); left undefined it raises exc (8086 behaviour).

module div_seq (
  input  logic      clk,
  input  logic      rst_n,
  div_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic        signed_r, word_r;
  logic [31:0] x_r;
  logic [15:0] y_r;
  logic [15:0] d_r, rem_r, quo_r;
  logic [3:0]  cnt_r;
  logic        exc_r;
  logic [31:0] out_r;

  // Operand signs and magnitudes, derived from the latched operands.
  logic        x_neg, y_neg;
  logic [31:0] x_abs;
  logic [15:0] y_abs;
  logic [15:0] hi_abs, lo_abs, d_abs;
  logic        div_zero, prep_ovf;

  always_comb begin
    x_neg  = signed_r & (word_r ? x_r[31] : x_r[15]);
    y_neg  = signed_r & (word_r ? y_r[15] : y_r[7]);
    // Low bits of a 32-bit negate equal the 16-bit negate, so byte mode
    // can reuse the same subtractors.
    x_abs  = x_neg ? (32'd0 - x_r) : x_r;
    y_abs  = y_neg ? (16'd0 - y_r) : y_r;
    hi_abs = word_r ? x_abs[31:16] : {8'd0, x_abs[15:8]};
    // Byte-mode low half is left-aligned so the shift-out bit is always
    // quo_r[15]; after 8 shifts the quotient lands in quo_r[7:0].
    lo_abs = word_r ? x_abs[15:0] : {x_abs[7:0], 8'd0};
    d_abs  = word_r ? y_abs : {8'd0, y_abs[7:0]};
    div_zero = (d_abs == 16'd0);
    prep_ovf = (hi_abs >= d_abs);
  end

  // One restoring step: 17-bit shifted remainder against the divisor.
  logic [16:0] shifted;
  logic [15:0] diff;
  logic        no_borrow;

  always_comb begin
    shifted   = {rem_r, quo_r[15]};
    diff      = shifted[15:0] - d_r;
    no_borrow = shifted[16] | (shifted[15:0] >= d_r);
  end

  // Sign fix-up and signed range check on the finished magnitudes.
  logic [15:0] q_mag, q_fin, r_fin, pos_lim, neg_lim;
  logic        neg_q, range_err;
  logic [31:0] fix_out;

  always_comb begin
    q_mag   = word_r ? quo_r : {8'd0, quo_r[7:0]};
    neg_q   = x_neg ^ y_neg;
    q_fin   = neg_q ? (16'd0 - q_mag) : q_mag;
    r_fin   = x_neg ? (16'd0 - rem_r) : rem_r;
    pos_lim = word_r ? 16'h7FFF : 16'h007F;
`ifdef DIV_NEG_MAX_EN
    neg_lim = word_r ? 16'h8000 : 16'h0080;
`else
    neg_lim = pos_lim;
`endif
    range_err = signed_r & (q_mag > (neg_q ? neg_lim : pos_lim));
    fix_out   = word_r ? {r_fin, q_fin} : {16'd0, r_fin[7:0], q_fin[7:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = PREP;
      end
      PREP:    state_nxt = (div_zero || prep_ovf) ? DONE : ITER;
      ITER:    if (cnt_r == 4'd0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    bus.exc = bus.done & exc_r;
    bus.out = out_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signed_r <= 1'b0;
      word_r   <= 1'b0;
      x_r      <= 32'd0;
      y_r      <= 16'd0;
      d_r      <= 16'd0;
      rem_r    <= 16'd0;
      quo_r    <= 16'd0;
      cnt_r    <= 4'd0;
      exc_r    <= 1'b0;
      out_r    <= 32'd0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          signed_r <= bus.signed_op;
          word_r   <= bus.word_op;
          x_r      <= bus.x;
          y_r      <= bus.y;
          exc_r    <= 1'b0;
        end
        PREP: begin
          rem_r <= hi_abs;
          quo_r <= lo_abs;
          d_r   <= d_abs;
          cnt_r <= word_r ? 4'd15 : 4'd7;
          exc_r <= div_zero | prep_ovf;
        end
        ITER: begin
          rem_r <= no_borrow ? diff : shifted[15:0];
          quo_r <= {quo_r[14:0], no_borrow};
          cnt_r <= cnt_r - 4'd1;
        end
        // out is loaded on entry to DONE so it is valid alongside done.
        FIX: begin
          exc_r <= range_err;
          if (!range_err) out_r <= fix_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq with a arithmetic reference model

module tb_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  div_seq_if bus ();

  div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          e;
    logic [31:0] o;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_out = 32'd0;

  // Reference: plain integer division with the architectural rules.
  task automatic model(input bit sgn, input bit wrd, input logic [31:0] xv,
                       input logic [15:0] yv, output bit e, output int lat,
                       output logic [31:0] o);
    longint n, d, an, ad, q, r, wpow, qmax, qmin;
    logic signed [31:0] sx32;
    logic signed [15:0] sx16, sy16;
    logic signed [7:0]  sy8;
    sx32 = xv;
    sx16 = xv[15:0];
    sy16 = yv;
    sy8  = yv[7:0];
    wpow = wrd ? 65536 : 256;
    if (sgn) begin
      n = wrd ? longint'(sx32) : longint'(sx16);
      d = wrd ? longint'(sy16) : longint'(sy8);
    end else begin
      n = wrd ? longint'(xv) : longint'(xv[15:0]);
      d = wrd ? longint'(yv) : longint'(yv[7:0]);
    end
    an  = (n < 0) ? -n : n;
    ad  = (d < 0) ? -d : d;
    e   = 1'b0;
    lat = wrd ? 19 : 11;
    q   = 0;
    r   = 0;
    if (d == 0) begin
      e = 1'b1; lat = 2;
    end else if (an / ad >= wpow) begin
      e = 1'b1; lat = 2;
    end else begin
      q = n / d;
      r = n - q * d;
      if (sgn) begin
        qmax = wpow / 2 - 1;
`ifdef DIV_NEG_MAX_EN
        qmin = -(wpow / 2);
`else
        qmin = -qmax;
`endif
        if (q > qmax || q < qmin) e = 1'b1;
      end
    end
    if (e)        o = last_out;
    else if (wrd) o = {r[15:0], q[15:0]};
    else          o = {16'd0, r[7:0], q[7:0]};
    if (!e) last_out = o;
  endtask

  // Issue one op; optionally raise a stray start in cycle 'poke' (>=2).
  task automatic do_op(input bit sgn, input bit wrd, input logic [31:0] xv,
                       input logic [15:0] yv, input int poke);
    exp_t ex;
    int   c0, lat, n, p;
    bit   e;
    logic [31:0] o;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_op = sgn; bus.word_op = wrd;
    bus.x = xv; bus.y = yv;
    c0 = cyc;
    model(sgn, wrd, xv, yv, e, lat, o);
    ex.cyc = c0 + lat; ex.e = e; ex.o = o;
    sb.push_back(ex);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.x = $urandom; bus.y = 16'($urandom);
    bus.signed_op = 1'($urandom); bus.word_op = 1'($urandom);
    p = (poke > lat) ? 0 : poke;
    if (p >= 2) begin
      while (cyc < c0 + p) begin @(posedge clk); #1; end
      bus.start = 1'b1; bus.x = $urandom; bus.y = 16'($urandom);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); #1; n++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout cyc=%0d pending=%0d required=0", cyc, sb.size());
      sb.delete();
    end
  endtask

  exp_t mex;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          mex = sb.pop_front();
          if (cyc != mex.cyc) begin
            failures++;
            $display("FAIL done_cycle actual=%0d required=%0d", cyc, mex.cyc);
          end
          checks++;
          if (bus.exc != mex.e) begin
            failures++;
            $display("FAIL exc actual=%0b required=%0b", bus.exc, mex.e);
          end
          checks++;
          if (bus.out !== mex.o) begin
            failures++;
            $display("FAIL out actual=%08h required=%08h", bus.out, mex.o);
          end
          checks++;
          if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_at_done actual=%0b required=1", bus.busy);
          end
        end
      end else begin
        checks++;
        if (bus.exc !== 1'b0) begin
          failures++;
          $display("FAIL exc_without_done actual=%0b required=0", bus.exc);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks += 4;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_busy actual=%0b required=0", tag, bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL %s_done actual=%0b required=0", tag, bus.done); end
    if (bus.exc  !== 1'b0) begin failures++; $display("FAIL %s_exc actual=%0b required=0", tag, bus.exc); end
    if (bus.out  !== 32'd0) begin failures++; $display("FAIL %s_out actual=%08h required=0", tag, bus.out); end
  endtask

  initial begin
    int c0;
    bit sgn, wrd;
    logic [31:0] xv;
    logic [15:0] yv;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.word_op = 1'b0;
    bus.x = 32'd0; bus.y = 16'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    do_op(1'b0, 1'b1, 32'h00000064, 16'h0007, 0);
    do_op(1'b1, 1'b0, 32'h0000FFF9, 16'h0002, 0);
    do_op(1'b0, 1'b1, 32'h12345678, 16'h0000, 0);
    do_op(1'b0, 1'b1, 32'h00010000, 16'h0001, 0);
    do_op(1'b1, 1'b1, 32'hFFFF8000, 16'h0001, 0);
    do_op(1'b1, 1'b0, 32'h0000FF80, 16'h0001, 0);
    do_op(1'b1, 1'b1, 32'h00007FFF, 16'h0001, 0);
    do_op(1'b1, 1'b1, 32'h00008000, 16'h0001, 0);
    do_op(1'b0, 1'b0, 32'h0000FFFF, 16'h00FF, 0);
    do_op(1'b1, 1'b1, 32'hFFFFFF9C, 16'hFFF9, 0);
    do_op(1'b0, 1'b1, 32'h000003E8, 16'h000A, 5);

    for (int i = 0; i < 150; i++) begin
      sgn = 1'($urandom);
      wrd = 1'($urandom);
      xv  = $urandom;
      yv  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) yv = yv & 16'h000F;
      if ($urandom_range(0, 2) != 0) xv = xv >> $urandom_range(8, 31);
      if ($urandom_range(0, 1) == 0 && sgn) xv = 32'd0 - xv;
      do_op(sgn, wrd, xv, yv, ($urandom_range(0, 4) == 0) ? $urandom_range(2, 10) : 0);
    end

    // Reset abort mid-operation: no done may follow.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.word_op = 1'b1;
    bus.x = 32'h00000064; bus.y = 16'h0007;
    c0 = cyc;
    @(posedge clk); #1 bus.start = 1'b0;
    while (cyc < c0 + 8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1 rst_n = 1'b1;
    last_out = 32'd0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("post_abort");

    do_op(1'b0, 1'b0, 32'h00000064, 16'h0007, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
